// File: rtl/pr_swap_ctrl.sv
// Partial-reconfiguration swap sequencer for the PCIe application region:
// drain/gate TRN traffic, isolate, load configuration, reset the new module, await its signature.
module pr_swap_ctrl #(
  parameter int          CNT_W      = 16,
  parameter int          DRAIN_TO   = 1024,
  parameter int          CFG_TO     = 65535,
  parameter int          RST_CYCLES = 16,
  parameter int          RDY_TO     = 256,
  parameter logic [31:0] RDY_SIG    = 32'h5253_4D31
) (
  input  logic        trn_clk,
  input  logic        trn_reset,
  input  logic        rc_start_req,
  input  logic        trn_tsof_n,
  input  logic        trn_teof_n,
  input  logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rdst_rdy_n,
  input  logic        icap_done,
  input  logic [31:0] RM_rdy_sig,
  output logic        tx_gate,
  output logic        rx_gate,
  output logic        isolate,
  output logic        icap_start,
  output logic        rm_reset,
  output logic        busy,
  output logic        rc_done,
  output logic        rc_error,
  output logic [2:0]  rc_err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_ISOLATE, S_CONFIG, S_RST, S_WAIT_RDY, S_RELEASE, S_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TO - 1);
  localparam logic [CNT_W-1:0] CFG_LAST   = CNT_W'(CFG_TO - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RDY_LAST   = CNT_W'(RDY_TO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tx_in_pkt, rx_in_pkt;
  logic             tx_in_next, rx_in_next;
  logic             drained, cfg_ok, rdy_ok;
  logic             to_hit;
  logic [2:0]       to_code;

  // Packet tracking: SOF opens, EOF closes; a same-beat SOF+EOF leaves the flag clear.
  always_comb begin
    tx_in_next = tx_in_pkt;
    rx_in_next = rx_in_pkt;
    if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
      if (!trn_teof_n)      tx_in_next = 1'b0;
      else if (!trn_tsof_n) tx_in_next = 1'b1;
    end
    if (!trn_rsrc_rdy_n && !trn_rdst_rdy_n) begin
      if (!trn_reof_n)      rx_in_next = 1'b0;
      else if (!trn_rsof_n) rx_in_next = 1'b1;
    end
  end

  // Drain completion looks at the post-beat flags so an EOF beat releases DRAIN on the next edge.
  always_comb begin
    drained = !tx_in_next && !rx_in_next;
    cfg_ok  = (cnt != '0) && icap_done;
    rdy_ok  = (RM_rdy_sig == RDY_SIG);
    to_hit  = 1'b0;
    to_code = 3'd0;
    if (state == S_DRAIN && !drained && cnt == DRAIN_LAST) begin
      to_hit  = 1'b1;
      to_code = 3'd1;
    end else if (state == S_CONFIG && !cfg_ok && cnt == CFG_LAST) begin
      to_hit  = 1'b1;
      to_code = 3'd2;
    end else if (state == S_WAIT_RDY && !rdy_ok && cnt == RDY_LAST) begin
      to_hit  = 1'b1;
      to_code = 3'd3;
    end
  end

  assign tx_gate = (state != S_IDLE) && !tx_in_pkt;
  assign rx_gate = (state != S_IDLE) && !rx_in_pkt;

  always_ff @(posedge trn_clk or posedge trn_reset) begin
    if (trn_reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tx_in_pkt   <= 1'b0;
      rx_in_pkt   <= 1'b0;
      isolate     <= 1'b0;
      icap_start  <= 1'b0;
      rm_reset    <= 1'b0;
      busy        <= 1'b0;
      rc_done     <= 1'b0;
      rc_error    <= 1'b0;
      rc_err_code <= 3'd0;
    end else begin
      tx_in_pkt  <= tx_in_next;
      rx_in_pkt  <= rx_in_next;
      icap_start <= 1'b0;
      rc_done    <= 1'b0;
      if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
      if (to_hit) begin
        // A stalled packet is abandoned here so both gates close in ERROR.
        state       <= S_ERROR;
        cnt         <= '0;
        tx_in_pkt   <= 1'b0;
        rx_in_pkt   <= 1'b0;
        isolate     <= 1'b1;
        rm_reset    <= 1'b1;
        rc_error    <= 1'b1;
        rc_err_code <= to_code;
      end else begin
        case (state)
          S_IDLE: if (rc_start_req) begin
            state <= S_DRAIN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
          S_DRAIN: if (drained) begin
            state   <= S_ISOLATE;
            cnt     <= '0;
            isolate <= 1'b1;
          end
          S_ISOLATE: begin
            state      <= S_CONFIG;
            cnt        <= '0;
            icap_start <= 1'b1;
          end
          S_CONFIG: if (cfg_ok) begin
            state    <= S_RST;
            cnt      <= '0;
            rm_reset <= 1'b1;
          end
          S_RST: if (cnt == RST_LAST) begin
            state    <= S_WAIT_RDY;
            cnt      <= '0;
            rm_reset <= 1'b0;
          end
          S_WAIT_RDY: if (rdy_ok) begin
            state   <= S_RELEASE;
            cnt     <= '0;
            rc_done <= 1'b1;
          end
          S_RELEASE: begin
            state   <= S_IDLE;
            cnt     <= '0;
            isolate <= 1'b0;
            busy    <= 1'b0;
          end
          S_ERROR: if (rc_start_req) begin
            state       <= S_DRAIN;
            cnt         <= '0;
            isolate     <= 1'b0;
            rm_reset    <= 1'b0;
            rc_error    <= 1'b0;
            rc_err_code <= 3'd0;
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pr_swap_ctrl.sv
// Bench for pr_swap_ctrl: per-cycle stimulus tables, output edge events scored against an expected queue.
module tb_pr_swap_ctrl;

  localparam logic [31:0] RDY = 32'h5253_4D31;
  localparam int NEVER = 1000000;

  logic        trn_clk, trn_reset, rc_start_req;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tdst_rdy_n;
  logic        trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rdst_rdy_n;
  logic        icap_done;
  logic [31:0] RM_rdy_sig;
  logic        tx_gate, rx_gate, isolate, icap_start, rm_reset, busy, rc_done, rc_error;
  logic [2:0]  rc_err_code;
  logic        tsrc_raw, rdst_raw;

  // External gating the real system applies around the block.
  assign trn_tsrc_rdy_n = tsrc_raw | tx_gate;
  assign trn_rdst_rdy_n = rdst_raw | rx_gate;

  pr_swap_ctrl dut (
    .trn_clk(trn_clk), .trn_reset(trn_reset), .rc_start_req(rc_start_req),
    .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
    .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
    .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rdst_rdy_n(trn_rdst_rdy_n),
    .icap_done(icap_done), .RM_rdy_sig(RM_rdy_sig),
    .tx_gate(tx_gate), .rx_gate(rx_gate), .isolate(isolate), .icap_start(icap_start),
    .rm_reset(rm_reset), .busy(busy), .rc_done(rc_done), .rc_error(rc_error),
    .rc_err_code(rc_err_code)
  );

  // Clock and watchdog
  initial begin
    trn_clk = 1'b0;
    forever #5 trn_clk = ~trn_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard state
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [7:0]  prev_ev  = 8'h00;
  int          rise_code[8] = '{1, 3, 4, 6, 7, 8, 9, 10};
  int          fall_code[8] = '{2, 12, 5, 13, 16, 14, 15, 11};

  // Stimulus table
  int start_a, done_from, done_to, sig_from;
  int rx_first, rx_len, rx_retry_from, rx_retry_to;
  int tx_first, tx_len, tx_stall_from;
  logic [31:0] sig_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [10:0] outs();
    return {rc_err_code, busy, tx_gate, rx_gate, rc_error, rc_done, rm_reset, icap_start, isolate};
  endfunction

  task automatic ev_at(input int c, input int code);
    exp_q.push_back({8'(code), 24'(c)});
  endtask

  task automatic monitor();
    logic [10:0] o;
    logic [7:0]  cur;
    logic [31:0] ev;
    o = outs();
    cur = o[7:0];
    for (int code = 1; code <= 16; code++) begin
      for (int b = 0; b < 8; b++) begin
        if ((cur[b] && !prev_ev[b] && rise_code[b] == code) ||
            (!cur[b] && prev_ev[b] && fall_code[b] == code)) begin
          ev = {8'(code), 24'(cyc)};
          if (exp_q.size() == 0) check_eq("unexpected_event", ev, 32'h0);
          else check_eq("event", ev, exp_q.pop_front());
        end
      end
    end
    prev_ev = cur;
  endtask

  task automatic clear_stim();
    start_a = NEVER; done_from = NEVER; done_to = -NEVER;
    sig_from = NEVER; sig_val = 32'h0;
    rx_first = 0; rx_len = 0; rx_retry_from = NEVER; rx_retry_to = -NEVER;
    tx_first = 0; tx_len = 0; tx_stall_from = NEVER;
  endtask

  task automatic idle_inputs();
    rc_start_req = 1'b0; icap_done = 1'b0; RM_rdy_sig = 32'h0;
    trn_tsof_n = 1'b1; trn_teof_n = 1'b1; tsrc_raw = 1'b1; trn_tdst_rdy_n = 1'b0;
    trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_rdy_n = 1'b1; rdst_raw = 1'b0;
  endtask

  // Driver: inputs for cycle c
  task automatic drive(input int c);
    logic in_rx, in_tx, retry;
    in_rx = rx_len > 0 && c >= rx_first && c < rx_first + rx_len;
    in_tx = tx_len > 0 && c >= tx_first && c < tx_first + tx_len;
    retry = c >= rx_retry_from && c <= rx_retry_to;
    rc_start_req   = (c == start_a);
    icap_done      = (c >= done_from) && (c <= done_to);
    RM_rdy_sig     = (c >= sig_from) ? sig_val : 32'h0;
    trn_rsrc_rdy_n = !(in_rx || retry);
    trn_rsof_n     = !((in_rx && c == rx_first) || retry);
    trn_reof_n     = !(in_rx && c == rx_first + rx_len - 1);
    rdst_raw       = 1'b0;
    tsrc_raw       = !in_tx;
    trn_tsof_n     = !(in_tx && c == tx_first);
    trn_teof_n     = !(in_tx && c == tx_first + tx_len - 1);
    trn_tdst_rdy_n = (c >= tx_stall_from);
  endtask

  task automatic tick();
    @(posedge trn_clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic run(input int c0, input int c_end);
    cyc = c0;
    while (cyc < c_end) begin
      drive(cyc);
      tick();
    end
  endtask

  task automatic end_scenario(input string tag);
    check_eq({tag, "_pending"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Common opening: start at 0, config loaded in cycle d, RST then WAIT_RDY.
  task automatic expect_prefix(input int d);
    ev_at(1, 8); ev_at(1, 9); ev_at(1, 10);
    ev_at(2, 1); ev_at(3, 3); ev_at(4, 12);
    ev_at(d + 1, 4); ev_at(d + 17, 5);
  endtask

  task automatic async_reset_check(input string tag);
    logic [10:0] o;
    #3 trn_reset = 1'b1;
    #1 check_eq({tag, "_now"}, 32'(outs()), 32'h0);
    rc_start_req = 1'b1;
    repeat (2) @(posedge trn_clk);
    #1 check_eq({tag, "_hold"}, 32'(outs()), 32'h0);
    clear_stim();
    idle_inputs();
    #3 trn_reset = 1'b0;
    @(posedge trn_clk);
    #1;
    o = outs();
    prev_ev = o[7:0];
    exp_q.delete();
  endtask

  initial begin
    clear_stim();
    idle_inputs();
    trn_reset = 1'b0;
    #2 trn_reset = 1'b1;
    #1 check_eq("reset_outputs", 32'(outs()), 32'h0);
    repeat (2) @(posedge trn_clk);
    #2 trn_reset = 1'b0;
    @(posedge trn_clk);
    #1;

    // Idle swap
    clear_stim();
    start_a = 0; done_from = 10; done_to = 10; sig_from = 40; sig_val = RDY;
    expect_prefix(10);
    ev_at(41, 6);
    ev_at(42, 2); ev_at(42, 11); ev_at(42, 13); ev_at(42, 14); ev_at(42, 15);
    run(0, 46);
    check_eq("idle_swap_end", 32'(outs()), 32'h0);
    end_scenario("idle_swap");

    // RX packet in flight; icap_done held as a level from the first CONFIG cycle
    clear_stim();
    start_a = 0; rx_first = -1; rx_len = 4; rx_retry_from = 3; rx_retry_to = 20;
    done_from = 4; done_to = NEVER; sig_from = 22; sig_val = RDY;
    ev_at(1, 9); ev_at(1, 10);
    ev_at(3, 1); ev_at(3, 8);
    ev_at(4, 3); ev_at(5, 12); ev_at(6, 4); ev_at(22, 5); ev_at(23, 6);
    ev_at(24, 2); ev_at(24, 11); ev_at(24, 13); ev_at(24, 14); ev_at(24, 15);
    run(-1, 26);
    check_eq("rx_drain_end", 32'(outs()), 32'h0);
    end_scenario("rx_drain");

    // Single-beat TX at the start cycle, then async reset in CONFIG
    clear_stim();
    start_a = 0; tx_first = 0; tx_len = 1;
    ev_at(1, 8); ev_at(1, 9); ev_at(1, 10);
    ev_at(2, 1); ev_at(3, 3); ev_at(4, 12);
    run(0, 7);
    check_eq("config_outputs", 32'(outs()), 32'h0E1);
    end_scenario("single_beat");
    async_reset_check("rst_in_config");

    // Drain timeout with stalled TX packet, then restart from ERROR
    clear_stim();
    start_a = 0; tx_first = -1; tx_len = 100000; tx_stall_from = 0;
    ev_at(1, 8); ev_at(1, 10);
    ev_at(1025, 1); ev_at(1025, 4); ev_at(1025, 7); ev_at(1025, 9);
    run(-1, 1026);
    check_eq("drain_timeout_err", 32'(outs()), 32'h1F5);
    end_scenario("drain_timeout");
    start_a = 1030;
    ev_at(1031, 2); ev_at(1031, 5); ev_at(1031, 16);
    ev_at(1032, 1); ev_at(1033, 3); ev_at(1034, 12);
    run(1026, 1036);
    check_eq("restart_from_error", 32'(outs()), 32'h0E1);
    end_scenario("restart");
    async_reset_check("rst_after_drain");

    // Ready timeout: signature held at zero, then a near-miss signature
    for (int k = 0; k < 2; k++) begin
      clear_stim();
      start_a = 0; done_from = 5; done_to = 5; sig_from = 0;
      sig_val = (k == 0) ? 32'h0 : 32'h5253_4D30;
      expect_prefix(5);
      ev_at(278, 4); ev_at(278, 7);
      run(0, 279);
      check_eq((k == 0) ? "rdy_timeout_zero" : "rdy_timeout_wrong", 32'(outs()), 32'h3F5);
      end_scenario("rdy_timeout");
      async_reset_check("rst_after_rdy");
    end

    // Async reset while rm_reset is held
    clear_stim();
    start_a = 0; done_from = 5; done_to = 5;
    ev_at(1, 8); ev_at(1, 9); ev_at(1, 10);
    ev_at(2, 1); ev_at(3, 3); ev_at(4, 12); ev_at(6, 4);
    run(0, 10);
    check_eq("rst_outputs", 32'(outs()), 32'h0E5);
    end_scenario("rst_phase");
    async_reset_check("rst_in_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
